icache_unit: RTL

- Direct-mapped instruction cache on the fetch path.
- Responds to the 32-bit PC issued by the program counter unit. On a hit it returns INSTRUCTION with no stall. On a miss it stalls the CPU via BUSYWAIT and refills the block from instruction memory through a block-read handshake.
- Sits between the PC/fetch stage and the 1 KB instruction memory.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_word_mux.sv | 21 ++
 rtl/icache_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state type for the direct-mapped instruction cache.
package icache_pkg;

    // Geometry: 8 blocks of 4 x 32-bit words covering a 1 KB instruction space.
    localparam int INDEX_BITS    = 3;
    localparam int TAG_BITS      = 3;
    localparam int WORD_SEL_BITS = 2;
    localparam int WORD_W        = 32;
    localparam int BLOCK_W       = 128;
    localparam int NUM_BLOCKS    = 1 << INDEX_BITS;
    localparam int MEM_ADDR_W    = TAG_BITS + INDEX_BITS;

    // Byte-address field positions: [1:0] byte, [3:2] word, [6:4] index, [9:7] tag.
    localparam int WORD_LSB  = 2;
    localparam int INDEX_LSB = WORD_LSB + WORD_SEL_BITS;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEM_READ = 2'b01,
        UPDATE   = 2'b10
    } state_e;

endpackage

// File: rtl/icache_word_mux.sv
// 4:1 word selector picking one 32-bit instruction out of a 128-bit cache block.
module icache_word_mux
    import icache_pkg::*;
(
    input  logic [WORD_SEL_BITS-1:0] sel_i,
    input  logic [BLOCK_W-1:0]       block_i,
    output logic [WORD_W-1:0]        word_o
);

    localparam int NUM_WORDS = 1 << WORD_SEL_BITS;

    logic [WORD_W-1:0] words [NUM_WORDS];

    // Word 0 lives in the lowest 32 bits of the block.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        assign words[gi] = block_i[gi*WORD_W +: WORD_W];
    end

    assign word_o = words[sel_i];

endmodule

// File: rtl/icache_unit.sv
// Direct-mapped, read-only instruction cache with zero-cycle hits and block refill on miss.
module icache_unit
    import icache_pkg::state_e, icache_pkg::IDLE, icache_pkg::UPDATE,
           icache_pkg::TAG_BITS, icache_pkg::INDEX_BITS, icache_pkg::WORD_SEL_BITS,
           icache_pkg::WORD_W, icache_pkg::BLOCK_W, icache_pkg::NUM_BLOCKS,
           icache_pkg::MEM_ADDR_W, icache_pkg::WORD_LSB, icache_pkg::INDEX_LSB,
           icache_pkg::TAG_LSB;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           ADDRESS,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [WORD_SEL_BITS-1:0] word_w;
    logic [INDEX_BITS-1:0]    index_w;
    logic [TAG_BITS-1:0]      tag_w;
    logic                     unused_addr_bits;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_arr  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_arr [NUM_BLOCKS];

    state_e                state_q;
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [INDEX_BITS-1:0] miss_index_q;
    logic                  mem_read_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;

    logic              hit;
    logic              fill_en;
    logic [WORD_W-1:0] word_sel;

    // Byte offset and everything above the 1 KB space play no part in the lookup.
    assign word_w           = ADDRESS[WORD_LSB  +: WORD_SEL_BITS];
    assign index_w          = ADDRESS[INDEX_LSB +: INDEX_BITS];
    assign tag_w            = ADDRESS[TAG_LSB   +: TAG_BITS];
    assign unused_addr_bits = ^{ADDRESS[31:10], ADDRESS[1:0]};

    assign hit     = valid_q[index_w] && (tag_arr[index_w] == tag_w);
    // The block lands on the edge where memory drops busy; reset on that edge wins.
    assign fill_en = !RESET && (state_q == icache_pkg::MEM_READ) && !MEM_BUSYWAIT;

    icache_word_mux u_word_mux (
        .sel_i   (word_w),
        .block_i (data_arr[index_w]),
        .word_o  (word_sel)
    );

    assign INSTRUCTION = ((state_q == IDLE) && hit) ? word_sel : '0;
    assign BUSYWAIT    = !RESET && ((state_q != IDLE) || !hit);
    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = mem_addr_q;

    // Refill storage: the whole block and its tag are overwritten, no writeback needed.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_arr[miss_index_q] <= MEM_READDATA;
            tag_arr[miss_index_q]  <= miss_tag_q;
        end
    end

    // Miss FSM: latch the miss, hold the block request until memory answers, settle one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        miss_tag_q   <= tag_w;
                        miss_index_q <= index_w;
                        mem_read_q   <= 1'b1;
                        mem_addr_q   <= {tag_w, index_w};
                        state_q      <= icache_pkg::MEM_READ;
                    end
                end
                icache_pkg::MEM_READ: begin
                    if (fill_en) begin
                        valid_q[miss_index_q] <= 1'b1;
                        mem_read_q            <= 1'b0;
                        state_q               <= UPDATE;
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule
